// File: rtl/turbo_encoder_pkg.sv
// Shared definitions for the turbo link encoder and decoder.
//   state_e : encoder block FSM states
//   G0, G1  : RSC generators (octal 13 feedback, 15 parity); bit 3 is the
//             input term, bits 2..0 tap the state bits {s0, s1, s2}
//   TAIL    : termination symbols per constituent trellis
package turbo_pkg;

  typedef enum logic [1:0] {LOAD, ENCODE, TERM1, TERM2} state_e;

  localparam logic [3:0] G0 = 4'o13;
  localparam logic [3:0] G1 = 4'o15;

  localparam int unsigned TAIL = 3;

endpackage

// File: rtl/turbo_encoder_if.sv
// Bit-serial input stream and triplet output stream of the turbo encoder.
//   master : the encoder (sinks in_*, sources out_* and in_ready)
//   slave  : the surrounding environment
interface turbo_encoder_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic out_sys;
  logic out_p1;
  logic out_p2;
  logic out_tail;
  logic out_last;

  modport master (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_sys, out_p1, out_p2, out_tail, out_last
  );

  modport slave (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_sys, out_p1, out_p2, out_tail, out_last
  );
endinterface

// File: rtl/turbo_encoder_rsc.sv
// 8-state recursive systematic convolutional encoder (13/15 octal).
//   u_i    : information bit          en_i  : advance the trellis one step
//   term_i : drive the input so feedback is zero (termination)
//   clr_i  : synchronous clear to state 0 (takes priority over en_i)
//   sys_o  : bit actually fed to the trellis  z_o : parity bit
module rsc_encoder
  import turbo_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic u_i,
  input  logic en_i,
  input  logic term_i,
  input  logic clr_i,
  output logic sys_o,
  output logic z_o
);

  // s_q = {s0, s1, s2}
  logic [2:0] s_q, s_d;
  logic       fb_taps;
  logic       f;

  always_comb begin
    fb_taps = ^(s_q & G0[2:0]);
    // During termination the input cancels the feedback taps, so f = 0.
    sys_o   = term_i ? fb_taps : u_i;
    f       = sys_o ^ fb_taps;
    z_o     = f ^ (^(s_q & G1[2:0]));
    s_d     = s_q;
    if (clr_i) begin
      s_d = '0;
    end else if (en_i) begin
      s_d = {f, s_q[2:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/turbo_encoder.sv
// Rate-1/3 PCCC turbo encoder. Buffers K bits, then streams K systematic /
// parity-1 / parity-2 triplets (parity-2 over the QPP-interleaved block),
// followed by 3 tail triplets for each constituent encoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : input bit stream and output triplet stream (master side)
module turbo_encoder
  import turbo_pkg::*;
#(
  parameter int unsigned K  = 40,
  parameter int unsigned F1 = 3,
  parameter int unsigned F2 = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  turbo_encoder_if.master bus
);

  localparam int unsigned    IW     = $clog2(K);
  localparam logic [IW-1:0]  KM1    = IW'(K - 1);
  localparam logic [IW:0]    KW     = (IW + 1)'(K);
  localparam logic [IW-1:0]  G_INIT = IW'((F1 + F2) % K);
  localparam logic [IW-1:0]  G_STEP = IW'((2 * F2) % K);
  localparam logic [1:0]     T_LAST = 2'(TAIL - 1);

  state_e        state_q, state_d;
  logic [K-1:0]  buf_q;
  logic [IW-1:0] wcnt_q, wcnt_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] pi_q, pi_d;
  logic [IW-1:0] g_q, g_d;
  logic [1:0]    tcnt_q, tcnt_d;
  logic          in_ready_q, in_ready_d;
  logic          valid_q, valid_d;
  logic          sys_q, sys_d, p1_q, p1_d, p2_q, p2_d;
  logic          tail_q, tail_d, last_q, last_d;

  logic          step_en, accept, clr;
  logic          en1, en2, term1, term2;
  logic          sys1, sys2, z1, z2;
  logic [IW:0]   pi_sum, g_sum;

  rsc_encoder u_rsc1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .u_i    (buf_q[i_q]),
    .en_i   (en1),
    .term_i (term1),
    .clr_i  (clr),
    .sys_o  (sys1),
    .z_o    (z1)
  );

  rsc_encoder u_rsc2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .u_i    (buf_q[pi_q]),
    .en_i   (en2),
    .term_i (term2),
    .clr_i  (clr),
    .sys_o  (sys2),
    .z_o    (z2)
  );

  always_comb begin
    step_en = !valid_q || bus.out_ready;
    accept  = bus.in_valid && in_ready_q;
    // Both operands are < K, so one conditional subtract implements mod K.
    pi_sum  = {1'b0, pi_q} + {1'b0, g_q};
    g_sum   = {1'b0, g_q} + {1'b0, G_STEP};

    state_d = state_q;
    wcnt_d  = wcnt_q;
    i_d     = i_q;
    pi_d    = pi_q;
    g_d     = g_q;
    tcnt_d  = tcnt_q;
    clr     = 1'b0;
    en1     = 1'b0;
    en2     = 1'b0;
    term1   = 1'b0;
    term2   = 1'b0;
    valid_d = valid_q;
    sys_d   = sys_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    tail_d  = tail_q;
    last_d  = last_q;

    if (step_en) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      LOAD: begin
        if (accept) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == KM1) begin
            clr     = 1'b1;
            wcnt_d  = '0;
            i_d     = '0;
            pi_d    = '0;
            g_d     = G_INIT;
            state_d = ENCODE;
          end
        end
      end
      ENCODE: begin
        if (step_en) begin
          en1     = 1'b1;
          en2     = 1'b1;
          valid_d = 1'b1;
          sys_d   = sys1;
          p1_d    = z1;
          p2_d    = z2;
          tail_d  = 1'b0;
          last_d  = 1'b0;
          pi_d    = (pi_sum >= KW) ? IW'(pi_sum - KW) : pi_sum[IW-1:0];
          g_d     = (g_sum >= KW) ? IW'(g_sum - KW) : g_sum[IW-1:0];
          if (i_q == KM1) begin
            i_d     = '0;
            tcnt_d  = '0;
            state_d = TERM1;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      TERM1: begin
        if (step_en) begin
          en1     = 1'b1;
          term1   = 1'b1;
          valid_d = 1'b1;
          sys_d   = sys1;
          p1_d    = z1;
          p2_d    = 1'b0;
          tail_d  = 1'b1;
          last_d  = 1'b0;
          tcnt_d  = tcnt_q + 1'b1;
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            state_d = TERM2;
          end
        end
      end
      TERM2: begin
        if (step_en) begin
          en2     = 1'b1;
          term2   = 1'b1;
          valid_d = 1'b1;
          sys_d   = sys2;
          p1_d    = 1'b0;
          p2_d    = z2;
          tail_d  = 1'b1;
          last_d  = (tcnt_q == T_LAST);
          tcnt_d  = tcnt_q + 1'b1;
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            wcnt_d  = '0;
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Input stays closed until the out_last beat has been taken.
    in_ready_d = (state_d == LOAD) && !valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      buf_q      <= '0;
      wcnt_q     <= '0;
      i_q        <= '0;
      pi_q       <= '0;
      g_q        <= '0;
      tcnt_q     <= '0;
      in_ready_q <= 1'b0;
      valid_q    <= 1'b0;
      sys_q      <= 1'b0;
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
      tail_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      i_q        <= i_d;
      pi_q       <= pi_d;
      g_q        <= g_d;
      tcnt_q     <= tcnt_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
      sys_q      <= sys_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      tail_q     <= tail_d;
      last_q     <= last_d;
      if (accept) begin
        buf_q[wcnt_q] <= bus.in_bit;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_sys   = sys_q;
  assign bus.out_p1    = p1_q;
  assign bus.out_p2    = p2_q;
  assign bus.out_tail  = tail_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_turbo_encoder.sv
// Self-checking bench for turbo_encoder (K=40, F1=3, F2=10).
module tb_turbo_encoder;
  import turbo_pkg::*;

  localparam int K  = 40;
  localparam int F1 = 3;
  localparam int F2 = 10;
  localparam int NB = K + 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  turbo_encoder_if bus ();

  turbo_encoder #(.K(K), .F1(F1), .F2(F2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] beats[$];      // {tail, last, sys, p1, p2}
  int         pis[$];
  logic [4:0] exp_beats[NB];
  int         in_ready_bad = 0;
  bit         stall_en     = 1'b0;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Handshakes are observed at negedge, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready)
        beats.push_back({bus.out_tail, bus.out_last, bus.out_sys, bus.out_p1, bus.out_p2});
      if (dut.state_q == ENCODE && (!bus.out_valid || bus.out_ready))
        pis.push_back(int'(dut.pi_q));
      if (dut.state_q != LOAD && bus.in_ready)
        in_ready_bad++;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.out_ready = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // Reference encoder: direct QPP formula, bit-level RSC equations.
  task automatic build_expected(input logic [K-1:0] blk);
    bit a1, b1, c1, a2, b2, c2, u1, u2, f, z1, z2, u, z;
    int p;
    {a1, b1, c1, a2, b2, c2} = '0;
    for (int i = 0; i < K; i++) begin
      p  = (F1 * i + F2 * i * i) % K;
      u1 = blk[i];
      u2 = blk[p];
      f  = u1 ^ b1 ^ c1; z1 = f ^ a1 ^ c1; {a1, b1, c1} = {f, a1, b1};
      f  = u2 ^ b2 ^ c2; z2 = f ^ a2 ^ c2; {a2, b2, c2} = {f, a2, b2};
      exp_beats[i] = {1'b0, 1'b0, u1, z1, z2};
    end
    for (int t = 0; t < 3; t++) begin
      u = b1 ^ c1; z = a1 ^ c1; {a1, b1, c1} = {1'b0, a1, b1};
      exp_beats[K + t] = {1'b1, 1'b0, u, z, 1'b0};
    end
    for (int t = 0; t < 3; t++) begin
      u = b2 ^ c2; z = a2 ^ c2; {a2, b2, c2} = {1'b0, a2, b2};
      exp_beats[K + 3 + t] = {1'b1, t == 2, u, 1'b0, z};
    end
  endtask

  task automatic load_block(input logic [K-1:0] blk);
    int cnt;
    for (int j = 0; j < K; j++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = blk[j];
      cnt = 0;
      while (!bus.in_ready && cnt < 400) begin
        @(posedge clk); #1; cnt++;
      end
      if (cnt >= 400) check($sformatf("load_timeout_bit%0d", j), 0, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int cnt = 0;
    while (beats.size() < n && cnt < 3000) begin
      @(posedge clk); cnt++;
    end
    #1;
    check(tag, int'(beats.size() >= n), 1);
  endtask

  task automatic compare_stream(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_nbeats"}, beats.size(), NB);
    for (int j = 0; j < NB && j < beats.size(); j++)
      check($sformatf("%s_beat%0d", tag, j), int'(beats[j]), int'(exp_beats[j]));
  endtask

  task automatic check_rsc_zero(input string tag);
    check({tag, "_rsc1_state"}, int'(dut.u_rsc1.s_q), 0);
    check({tag, "_rsc2_state"}, int'(dut.u_rsc2.s_q), 0);
  endtask

  logic [K-1:0] blk;
  logic [63:0]  rnd;
  logic [K-1:0] seen;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values.
    #2 rst_n = 1'b0;
    #2;
    check("rst_outputs", int'({bus.in_ready, bus.out_valid, bus.out_sys, bus.out_p1,
                               bus.out_p2, bus.out_tail, bus.out_last}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check("in_ready_before_edge", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    check("in_ready_after_release", int'(bus.in_ready), 1);

    // All-zero block, latency and interleaver probe.
    beats.delete(); pis.delete();
    load_block('0);
    check("lat_n1_out_valid", int'(bus.out_valid), 0);
    check("lat_n1_in_ready", int'(bus.in_ready), 0);
    check("lat_n1_state", int'(dut.state_q), int'(ENCODE));
    @(posedge clk); #1;
    check("lat_n2_out_valid", int'(bus.out_valid), 1);
    wait_beats(NB, "zero_done");
    repeat (4) @(posedge clk);
    #1;
    check("zero_nbeats", beats.size(), NB);
    for (int j = 0; j < NB && j < beats.size(); j++)
      check($sformatf("zero_beat%0d", j), int'(beats[j]),
            int'({j >= K, j == NB - 1, 3'b000}));
    check("pi_count", pis.size(), K);
    if (pis.size() >= 4) begin
      check("pi0", pis[0], 0);
      check("pi1", pis[1], 13);
      check("pi2", pis[2], 6);
      check("pi3", pis[3], 19);
    end
    seen = '0;
    foreach (pis[j]) if (pis[j] < K) seen[pis[j]] = 1'b1;
    check("pi_permutation", $countones(seen), K);
    check_rsc_zero("zero");

    // Impulse at bit 0.
    blk = '0; blk[0] = 1'b1;
    build_expected(blk);
    beats.delete();
    load_block(blk);
    wait_beats(NB, "imp_done");
    check("imp_sys0", int'(beats[0][2]), 1);
    for (int j = 0; j < 4; j++)
      check($sformatf("imp_p1p2_%0d", j), int'(beats[j][1:0]), 3);
    compare_stream("imp");
    check_rsc_zero("imp");

    // Random block, no stall then 30 % stall.
    rnd = {$urandom(), $urandom()};
    blk = rnd[K-1:0];
    build_expected(blk);
    beats.delete();
    load_block(blk);
    wait_beats(NB, "rnd_done");
    compare_stream("rnd");
    check_rsc_zero("rnd");

    stall_en = 1'b1;
    in_ready_bad = 0;
    beats.delete();
    load_block(blk);
    wait_beats(NB, "stall_done");
    compare_stream("stall");
    check("stall_in_ready_low", in_ready_bad, 0);
    stall_en = 1'b0;

    // Reset in the middle of a block.
    rnd = {$urandom(), $urandom()};
    beats.delete();
    load_block(rnd[K-1:0]);
    wait_beats(20, "mid_20beats");
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", int'({bus.in_ready, bus.out_valid, bus.out_sys, bus.out_p1,
                                   bus.out_p2, bus.out_tail, bus.out_last}), 0);
    check("mid_rst_state", int'(dut.state_q), int'(LOAD));
    check("mid_rst_wcnt", int'(dut.wcnt_q), 0);
    @(negedge clk) rst_n = 1'b1;
    rnd = {$urandom(), $urandom()};
    blk = rnd[K-1:0];
    build_expected(blk);
    beats.delete();
    load_block(blk);
    wait_beats(NB, "post_rst_done");
    compare_stream("post_rst");
    check_rsc_zero("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
